rsa_modexp: RTL

- Modular-exponentiation controller for the RSA datapath: computes result = X^E mod M.
- Uses left-to-right square-and-multiply in the Montgomery domain.
- Sits directly upstream of the bit-serial Montgomery multiplier. It sequences every multiplication through a start/done handshake and consumes each product.
- The top level wires the mont_* ports to one multiplier instance.

---
 rtl/rsa_modexp_pkg.sv | 21 ++
 rtl/rsa_modexp.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_pkg.sv
// Shared types and constants for the RSA modular-exponentiation controller.
package rsa_pkg;

  localparam int DEF_WIDTH = 1024;

  typedef enum logic [3:0] {
    IDLE,
    TOMONT,
    W_TOMONT,
    SQR,
    W_SQR,
    MUL,
    W_MUL,
    NEXT,
    FROM,
    W_FROM
  } state_t;

  localparam logic [DEF_WIDTH-1:0] ONE = DEF_WIDTH'(1);

endpackage

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply X^E mod M in the Montgomery domain, driving an external
// Montgomery multiplier. Define RSA_MODEXP_LZ_SKIP_EN to skip leading-zero exponent bits.
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0] in_m,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_r2,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             mont_start,
  output logic [WIDTH-1:0] mont_a,
  output logic [WIDTH-1:0] mont_b,
  output logic [WIDTH-1:0] mont_m,
  input  logic [WIDTH-1:0] mont_result,
  input  logic             mont_done
);

  localparam int IW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] x_r, e_r, r2_r, acc, xt;
  logic [CW-1:0]    idx;
  logic             prod_ok;
  logic             e_bit;

  // A done arriving together with our own request cannot belong to it.
  assign prod_ok = mont_done && !mont_start;
  assign e_bit   = e_r[idx[IW-1:0]];

`ifdef RSA_MODEXP_LZ_SKIP_EN
  logic lz;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      result     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      mont_start <= 1'b0;
      mont_a     <= '0;
      mont_b     <= '0;
      mont_m     <= '0;
      x_r        <= '0;
      e_r        <= '0;
      r2_r       <= '0;
      acc        <= '0;
      xt         <= '0;
      idx        <= '0;
`ifdef RSA_MODEXP_LZ_SKIP_EN
      lz         <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
      mont_start <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x_r    <= in_x;
          e_r    <= in_e;
          mont_m <= in_m;
          r2_r   <= in_r2;
          acc    <= in_r;
          idx    <= CW'(WIDTH - 1);
          busy   <= 1'b1;
`ifdef RSA_MODEXP_LZ_SKIP_EN
          lz     <= 1'b1;
`endif
          state  <= TOMONT;
        end
        TOMONT: begin
          mont_a     <= x_r;
          mont_b     <= r2_r;
          mont_start <= 1'b1;
          state      <= W_TOMONT;
        end
        W_TOMONT: if (prod_ok) begin
          xt    <= mont_result;
          state <= SQR;
        end
        SQR: begin
`ifdef RSA_MODEXP_LZ_SKIP_EN
          // acc still holds R mod M here, and squaring it would return R again
          if (lz && !e_bit) begin
            if (idx == '0) state <= FROM;
            else           idx   <= idx - CW'(1);
          end else begin
            lz         <= 1'b0;
            mont_a     <= acc;
            mont_b     <= acc;
            mont_start <= 1'b1;
            state      <= W_SQR;
          end
`else
          mont_a     <= acc;
          mont_b     <= acc;
          mont_start <= 1'b1;
          state      <= W_SQR;
`endif
        end
        W_SQR: if (prod_ok) begin
          acc   <= mont_result;
          state <= e_bit ? MUL : NEXT;
        end
        MUL: begin
          mont_a     <= acc;
          mont_b     <= xt;
          mont_start <= 1'b1;
          state      <= W_MUL;
        end
        W_MUL: if (prod_ok) begin
          acc   <= mont_result;
          state <= NEXT;
        end
        NEXT: begin
          if (idx == '0) state <= FROM;
          else begin
            idx   <= idx - CW'(1);
            state <= SQR;
          end
        end
        FROM: begin
          mont_a     <= acc;
          mont_b     <= WIDTH'(ONE);
          mont_start <= 1'b1;
          state      <= W_FROM;
        end
        W_FROM: if (prod_ok) begin
          result <= mont_result;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
